// File: rtl/pipe_stage_elastic.sv
// Generic elastic pipeline boundary register: instr, pc and NUM_CH data
// channels behind a valid/ready handshake with a 2-entry skid buffer,
// a synchronous bubble-inserting flush and a saturating bubble counter.
module pipe_stage_elastic #(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [31:0]              in_pc,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]         bubble_cnt
);

    localparam int DW = NUM_CH * DATA_W;

    // Occupancy: main-only or main+skid; skid-only can never be reached.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t            state_p1;
    state_t            state_nxt;

    logic              vld_p1;
    logic              skid_vld_p1;
    logic [31:0]       main_instr_p1;
    logic [31:0]       main_pc_p1;
    logic [DW-1:0]     main_data_p1;
    logic [31:0]       skid_instr_p1;
    logic [31:0]       skid_pc_p1;
    logic [DW-1:0]     skid_data_p1;
    logic [CNT_W-1:0]  bubble_cnt_p1;

    logic              push;
    logic              pop;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid_in;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        return (v == {CNT_W{1'b1}}) ? v : v + one;
    endfunction

    assign vld_p1      = (state_p1 != EMPTY);
    assign skid_vld_p1 = (state_p1 == SKID);

    // in_ready is a pure function of registered state: no path from out_ready.
    assign in_ready   = !skid_vld_p1;
    assign out_valid  = vld_p1;
    assign out_instr  = vld_p1 ? main_instr_p1 : 32'd0;
    assign out_pc     = main_pc_p1;
    assign out_data   = main_data_p1;
    assign bubble_cnt = bubble_cnt_p1;

    assign push = in_valid & in_ready;
    assign pop  = vld_p1 & out_ready;

    // State register; reset and flush both return to EMPTY.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_p1 <= EMPTY;
        end else begin
            state_p1 <= state_nxt;
        end
    end

    // Next-state and load-enable decode; flush overrides any transfer.
    always_comb begin
        state_nxt      = state_p1;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        case (state_p1)
            EMPTY: begin
                if (push) begin
                    state_nxt    = FULL;
                    load_main_in = 1'b1;
                end
            end
            FULL: begin
                if (push && pop) begin
                    load_main_in = 1'b1;
                end else if (push) begin
                    state_nxt    = SKID;
                    load_skid_in = 1'b1;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            SKID: begin
                if (pop) begin
                    state_nxt      = FULL;
                    load_main_skid = 1'b1;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
        if (flush) begin
            state_nxt      = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid_in   = 1'b0;
        end
    end

    // Payload registers: change only on load; reset and flush zero them.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            main_instr_p1 <= 32'd0;
            main_pc_p1    <= 32'd0;
            main_data_p1  <= '0;
            skid_instr_p1 <= 32'd0;
            skid_pc_p1    <= 32'd0;
            skid_data_p1  <= '0;
        end else begin
            if (load_main_in) begin
                main_instr_p1 <= in_instr;
                main_pc_p1    <= in_pc;
                main_data_p1  <= in_data;
            end else if (load_main_skid) begin
                main_instr_p1 <= skid_instr_p1;
                main_pc_p1    <= skid_pc_p1;
                main_data_p1  <= skid_data_p1;
            end
            if (load_skid_in) begin
                skid_instr_p1 <= in_instr;
                skid_pc_p1    <= in_pc;
                skid_data_p1  <= in_data;
            end
        end
    end

    // Bubble counter: one per cycle without a live output word; flush keeps it.
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_p1 <= '0;
        end else if (!vld_p1) begin
            bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: single word, streaming, skid
// back-pressure, flush in SKID, bubble counting/saturation, reset when FULL.
module tb_pipe_stage_elastic;

    localparam int DATA_W = 32;
    localparam int NUM_CH = 4;
    localparam int DW     = DATA_W * NUM_CH;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_instr;
    logic [31:0]   in_pc;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [31:0]   out_pc;
    logic [DW-1:0] out_data;
    logic [15:0]   bubble_cnt;

    // Small-counter instance, kept idle for the saturation check.
    logic          reset4;
    logic          in_ready4;
    logic          out_valid4;
    logic [31:0]   out_instr4;
    logic [31:0]   out_pc4;
    logic [DW-1:0] out_data4;
    logic [3:0]    bubble_cnt4;

    int n_asrt = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_stage_elastic #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_data(out_data),
        .bubble_cnt(bubble_cnt)
    );

    pipe_stage_elastic #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset4), .flush(1'b0),
        .in_valid(1'b0), .in_ready(in_ready4),
        .in_instr(32'd0), .in_pc(32'd0), .in_data({DW{1'b0}}),
        .out_valid(out_valid4), .out_ready(1'b1),
        .out_instr(out_instr4), .out_pc(out_pc4), .out_data(out_data4),
        .bubble_cnt(bubble_cnt4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [DW-1:0] data);
        in_valid = v;
        in_instr = instr;
        in_pc    = pc;
        in_data  = data;
    endtask

    initial begin
        reset = 1'b1; reset4 = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 32'd0, 32'd0, '0);
        tick(); tick();

        // Reset state
        check("rst_out_valid", DW'(out_valid), DW'(1'b0));
        check("rst_out_instr", DW'(out_instr), '0);
        check("rst_out_pc", DW'(out_pc), '0);
        check("rst_out_data", out_data, '0);
        check("rst_in_ready", DW'(in_ready), DW'(1'b1));
        check("rst_bubble", DW'(bubble_cnt), '0);
        reset = 1'b0;

        // Ten idle cycles
        for (int i = 0; i < 10; i++) tick();
        check("idle_bubble10", DW'(bubble_cnt), DW'(16'd10));

        // Single word, one-cycle latency, then bubble with NOP instr
        drive(1'b1, 32'h24080005, 32'h3000, DW'(32'h11));
        tick();
        drive(1'b0, 32'd0, 32'd0, '0);
        check("single_valid", DW'(out_valid), DW'(1'b1));
        check("single_instr", DW'(out_instr), DW'(32'h24080005));
        check("single_pc", DW'(out_pc), DW'(32'h3000));
        check("single_data", out_data, DW'(32'h11));
        check("single_bubble", DW'(bubble_cnt), DW'(16'd11));
        tick();
        check("single_drain_valid", DW'(out_valid), DW'(1'b0));
        check("single_drain_instr", DW'(out_instr), '0);
        check("single_hold_pc", DW'(out_pc), DW'(32'h3000));
        check("single_hold_bubble", DW'(bubble_cnt), DW'(16'd11));

        // Stream of four words at full rate
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + 32'(i), 32'h3000 + 32'(4 * i),
                  {32'hD3 + 32'(i), 32'hC2 + 32'(i), 32'hB1 + 32'(i), 32'hA0 + 32'(i)});
            tick();
            check("stream_valid", DW'(out_valid), DW'(1'b1));
            check("stream_pc", DW'(out_pc), DW'(32'h3000 + 32'(4 * i)));
            check("stream_instr", DW'(out_instr), DW'(32'h100 + 32'(i)));
            check("stream_data", out_data,
                  {32'hD3 + 32'(i), 32'hC2 + 32'(i), 32'hB1 + 32'(i), 32'hA0 + 32'(i)});
            check("stream_in_ready", DW'(in_ready), DW'(1'b1));
        end
        drive(1'b0, 32'd0, 32'd0, '0);
        tick();
        check("stream_end_valid", DW'(out_valid), DW'(1'b0));
        check("stream_bubble", DW'(bubble_cnt), DW'(16'd12));

        // Back-pressure into the skid entry, then drain in order
        out_ready = 1'b0;
        drive(1'b1, 32'h200, 32'h3000, DW'(32'h55));
        tick();
        check("skid_full_pc", DW'(out_pc), DW'(32'h3000));
        check("skid_full_in_ready", DW'(in_ready), DW'(1'b1));
        drive(1'b1, 32'h201, 32'h3004, DW'(32'h66));
        tick();
        drive(1'b0, 32'd0, 32'd0, '0);
        check("skid_in_ready", DW'(in_ready), DW'(1'b0));
        check("skid_out_pc", DW'(out_pc), DW'(32'h3000));
        tick();
        check("skid_hold_pc", DW'(out_pc), DW'(32'h3000));
        check("skid_hold_in_ready", DW'(in_ready), DW'(1'b0));
        out_ready = 1'b1;
        check("skid_pop0_pc", DW'(out_pc), DW'(32'h3000));
        check("skid_pop0_data", out_data, DW'(32'h55));
        tick();
        check("skid_pop1_valid", DW'(out_valid), DW'(1'b1));
        check("skid_pop1_pc", DW'(out_pc), DW'(32'h3004));
        check("skid_pop1_instr", DW'(out_instr), DW'(32'h201));
        check("skid_pop1_data", out_data, DW'(32'h66));
        check("skid_pop1_in_ready", DW'(in_ready), DW'(1'b1));
        tick();
        check("skid_drained", DW'(out_valid), DW'(1'b0));
        check("skid_bubble", DW'(bubble_cnt), DW'(16'd13));

        // Flush while in SKID with a new word offered
        out_ready = 1'b0;
        drive(1'b1, 32'h300, 32'h3000, DW'(32'h77));
        tick();
        drive(1'b1, 32'h301, 32'h3004, DW'(32'h88));
        tick();
        check("flush_pre_in_ready", DW'(in_ready), DW'(1'b0));
        flush = 1'b1;
        drive(1'b1, 32'h400, 32'h4000, DW'(32'h99));
        tick();
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0, '0);
        check("flush_valid", DW'(out_valid), DW'(1'b0));
        check("flush_instr", DW'(out_instr), '0);
        check("flush_pc", DW'(out_pc), '0);
        check("flush_data", out_data, '0);
        check("flush_in_ready", DW'(in_ready), DW'(1'b1));
        check("flush_keeps_bubble", DW'(bubble_cnt), DW'(16'd14));
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flush_no_4000_valid", DW'(out_valid), DW'(1'b0));
            check("flush_no_4000_pc", DW'(out_pc), '0);
        end

        // Reset while FULL under back-pressure
        out_ready = 1'b0;
        drive(1'b1, 32'h500, 32'h5000, DW'(32'hABCD));
        tick();
        check("rstfull_pre_valid", DW'(out_valid), DW'(1'b1));
        drive(1'b0, 32'd0, 32'd0, '0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstfull_valid", DW'(out_valid), DW'(1'b0));
        check("rstfull_in_ready", DW'(in_ready), DW'(1'b1));
        check("rstfull_bubble", DW'(bubble_cnt), '0);
        check("rstfull_data", out_data, '0);
        check("rstfull_pc", DW'(out_pc), '0);

        // Saturation of a 4-bit bubble counter
        check("sat_reset", DW'(bubble_cnt4), '0);
        reset4 = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        check("sat_14", DW'(bubble_cnt4), DW'(4'd14));
        for (int i = 0; i < 6; i++) tick();
        check("sat_15", DW'(bubble_cnt4), DW'(4'd15));
        check("sat_in_ready", DW'(in_ready4), DW'(1'b1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed EX/MEM-style stage registers: one generic pipeline boundary register carrying instr, pc and NUM_CH data channels of DATA_W bits.
- Adds a valid/ready elastic handshake with a 2-entry skid buffer, so back-pressure is absorbed without a combinational ready path.
- Adds a synchronous flush that inserts a bubble (NOP) and a bubble-cycle counter for performance monitoring.
- Instantiated between any two pipeline stages (D/E, E/M, M/W) in place of the per-stage hand-written registers.

Parameters:
- DATA_W, 32, width of each data channel.
- NUM_CH, 4, number of data channels (e.g. RD2, EXT32, AO, MDUO).
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-high; clears all state.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream has a word.
- in_ready  out  1  stage can accept; registered, equals !skid_valid.
- in_instr  in  32  instruction word.
- in_pc  in  32  PC of instruction.
- in_data  in  NUM_CH*DATA_W  packed channels, channel k at bits [k*DATA_W +: DATA_W].
- out_valid  out  1  main register holds a live word.
- out_ready  in  1  downstream accepts.
- out_instr  out  32  main instr; forced to 0 (NOP) whenever out_valid=0.
- out_pc  out  32  main pc.
- out_data  out  NUM_CH*DATA_W  main data.
- bubble_cnt  out  CNT_W  count of cycles with out_valid=0, saturating.

Behaviour:
- Storage: main entry (main_valid, instr, pc, data) and skid entry (skid_valid, same fields). out_* come from the main entry.
- Transfers: push = in_valid & in_ready; pop = out_valid & out_ready.
- States:
  - EMPTY (main=0, skid=0)
  - FULL (main=1, skid=0)
  - SKID (main=1, skid=1); main=0 with skid=1 is unreachable.
- Transitions:
  - EMPTY: push -> FULL, word loaded into main.
  - FULL: push&pop -> FULL with new word in main. push&!pop -> SKID, word loaded into skid. !push&pop -> EMPTY. Neither -> hold.
  - SKID: in_ready=0, so no push. pop -> FULL, skid moves to main, skid_valid cleared. !pop -> hold.
- Latency: an accepted word appears on out_* the cycle after acceptance. Sustained throughput is 1 word/cycle while out_ready=1. Words leave in acceptance order; none are dropped or duplicated.
- Data fields change only on load. When out_valid=0, out_pc and out_data hold their last value; out_instr reads 0.
- Priority: reset > flush > normal operation.
  - Flush in any state gives EMPTY next cycle. main/skid instr, pc and data are written to 0. The input word presented that cycle is discarded even if in_valid=1. in_ready is 1 the following cycle.
  - Flush does not clear bubble_cnt.
- Reset: main_valid=0, skid_valid=0, all fields 0, bubble_cnt=0. Outputs after reset:
  - out_valid=0, out_instr=0, out_pc=0, out_data=0
  - in_ready=1, bubble_cnt=0
- A reset mid-transfer discards both entries with no partial state.
- bubble_cnt increments by 1 on each posedge where out_valid=0 and reset=0, and saturates at 2^CNT_W-1.
- in_ready depends only on registered state, with no combinational path from out_ready.

Test Plan:
- Reset, then in_valid=1, instr=0x24080005, pc=0x3000, data ch0=0x11, held 1 cycle with out_ready=1 -> out_valid=1 next cycle with instr 0x24080005, pc 0x3000, ch0 0x11; the following cycle out_valid=0 and out_instr=0.
- Stream pc 0x3000, 0x3004, 0x3008, 0x300C on consecutive cycles, out_ready=1 -> outputs on consecutive cycles in the same order; in_ready stays 1.
- Send pc 0x3000, then pc 0x3004 with out_ready=0 -> SKID, in_ready=0, out_pc=0x3000. Raise out_ready -> out_pc 0x3000, then 0x3004, in_ready back to 1. No loss.
- In SKID state, assert flush together with in_valid=1, pc=0x4000 -> next cycle out_valid=0, out_instr=0, out_pc=0, in_ready=1; pc 0x4000 never appears at the output.
- Hold in_valid=0 for 10 cycles after reset -> bubble_cnt=10. Then a CNT_W=4 instance held idle 20 cycles -> bubble_cnt saturates at 15.
- Assert reset while FULL with out_ready=0 -> next cycle out_valid=0, in_ready=1, bubble_cnt=0, out_data=0.
